// File: rtl/ov7670_pixel_writer.sv
// ov7670_pixel_writer
//   Write-side front end of the blur pipeline. Samples the OV7670 byte
//   stream and pairs bytes into RGB444 pixels. Each pixel is tagged with
//   its column and its row modulo 4, which together address the line-buffer
//   write port. Frame and line framing are enforced here, and malformed
//   lines are flagged.
//
// Parameters
//   H_PIXELS   active pixels per line; columns at or beyond are dropped
//   V_LINES    active lines per frame; frameDone follows line V_LINES-1
//
// Ports
//   writeClk   camera pixel clock, all logic on the rising edge
//   rstN       asynchronous active-low reset
//   vsync      camera vsync, high = vertical blanking
//   href       camera href, high = valid byte on camData
//   camData    camera data byte
//   pixelOut   assembled pixel {R[3:0],G[3:0],B[3:0]}, held between strobes
//   pixelValid one-cycle strobe qualifying pixelOut/outX/outY
//   outX       column of pixelOut (0..H_PIXELS-1)
//   outY       row index mod 4 of pixelOut
//   lineDone   one-cycle pulse at each line end (href falling)
//   frameDone  one-cycle pulse when line V_LINES-1 completes
//   lineError  sticky malformed-line flag, cleared at frame start
//
// Optional build macro OV7670_PIXEL_WRITER_STATS_EN adds:
//   frameCount[15:0]  completed frames, wrapping
//   errorCount[7:0]   malformed lines, saturating at 255
module ov7670_pixel_writer #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic        writeClk,
    input  logic        rstN,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  camData,
    output logic [11:0] pixelOut,
    output logic        pixelValid,
    output logic [9:0]  outX,
    output logic [1:0]  outY,
    output logic        lineDone,
    output logic        frameDone,
    output logic        lineError
`ifdef OV7670_PIXEL_WRITER_STATS_EN
    ,
    output logic [15:0] frameCount,
    output logic [7:0]  errorCount
`endif
);

    localparam int LC_W = $clog2(V_LINES + 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        BYTE_LO,
        BYTE_HI
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              vsync_d;
    logic [7:0]        hi_byte;
    logic [10:0]       x_cnt;
    logic [LC_W-1:0]   line_count;

    logic              frame_start;
    logic              take_hi;
    logic              take_lo;
    logic              end_line;
    logic              partial;
    logic              in_range;
    logic              last_line;
    logic              line_bad_now;

    assign in_range     = (x_cnt < 11'(H_PIXELS));
    assign last_line    = (line_count == LC_W'(V_LINES - 1));
    // A line is malformed if it ends mid-pixel or with the wrong pixel count.
    assign line_bad_now = partial || (x_cnt != 11'(H_PIXELS));

    always_ff @(posedge writeClk or negedge rstN) begin
        if (!rstN) begin
            state <= WAIT_FRAME;
        end else begin
            state <= next_state;
        end
    end

    // vsync high outside WAIT_FRAME aborts the frame and beats a same-cycle href.
    always_comb begin
        next_state = state;
        case (state)
            WAIT_FRAME: if (vsync_d && !vsync) next_state = WAIT_LINE;
            WAIT_LINE: begin
                if (vsync)     next_state = WAIT_FRAME;
                else if (href) next_state = BYTE_LO;
            end
            BYTE_LO, BYTE_HI: begin
                if (vsync)          next_state = WAIT_FRAME;
                else if (href)      next_state = (state == BYTE_LO) ? BYTE_HI : BYTE_LO;
                else if (last_line) next_state = WAIT_FRAME;
                else                next_state = WAIT_LINE;
            end
            default: next_state = WAIT_FRAME;
        endcase
    end

    always_comb begin
        frame_start = (state == WAIT_FRAME) && vsync_d && !vsync;
        take_hi     = !vsync && href && ((state == WAIT_LINE) || (state == BYTE_HI));
        take_lo     = !vsync && href && (state == BYTE_LO);
        end_line    = !vsync && !href && ((state == BYTE_LO) || (state == BYTE_HI));
        partial     = !vsync && !href && (state == BYTE_LO);
    end

    always_ff @(posedge writeClk or negedge rstN) begin
        if (!rstN) begin
            vsync_d    <= 1'b0;
            hi_byte    <= '0;
            x_cnt      <= '0;
            line_count <= '0;
            pixelOut   <= '0;
            pixelValid <= 1'b0;
            outX       <= '0;
            outY       <= '0;
            lineDone   <= 1'b0;
            frameDone  <= 1'b0;
            lineError  <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            pixelValid <= 1'b0;
            lineDone   <= 1'b0;
            frameDone  <= 1'b0;

            // x_cnt is cleared here too so an aborted line cannot leak its column.
            if (frame_start) begin
                outY       <= '0;
                line_count <= '0;
                lineError  <= 1'b0;
                x_cnt      <= '0;
            end

            if (take_hi) begin
                hi_byte <= camData;
            end

            if (take_lo) begin
                if (in_range) begin
                    pixelOut   <= {hi_byte[3:0], camData};
                    outX       <= x_cnt[9:0];
                    pixelValid <= 1'b1;
                end else begin
                    lineError  <= 1'b1;
                end
                // Saturate so an absurdly long line cannot wrap back into range.
                if (x_cnt != 11'd1023) begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end

            if (end_line) begin
                lineDone   <= 1'b1;
                frameDone  <= last_line;
                if (line_bad_now) begin
                    lineError <= 1'b1;
                end
                x_cnt      <= '0;
                outY       <= outY + 2'd1;
                line_count <= line_count + 1'b1;
            end
        end
    end

`ifdef OV7670_PIXEL_WRITER_STATS_EN
    // line_bad remembers an overflow pixel earlier in the current line.
    logic line_bad;

    always_ff @(posedge writeClk or negedge rstN) begin
        if (!rstN) begin
            frameCount <= '0;
            errorCount <= '0;
            line_bad   <= 1'b0;
        end else begin
            if (frame_start) begin
                line_bad <= 1'b0;
            end
            if (take_lo && !in_range) begin
                line_bad <= 1'b1;
            end
            if (end_line) begin
                line_bad <= 1'b0;
                if (last_line) begin
                    frameCount <= frameCount + 16'd1;
                end
                if ((line_bad || line_bad_now) && (errorCount != 8'hFF)) begin
                    errorCount <= errorCount + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_pixel_writer.sv
`timescale 1ns/1ps
module tb_ov7670_pixel_writer;

    localparam int H = 640;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        vsync;
    logic        href;
    logic [7:0]  camData;
    logic [11:0] pixelOut;
    logic        pixelValid;
    logic [9:0]  outX;
    logic [1:0]  outY;
    logic        lineDone;
    logic        frameDone;
    logic        lineError;
`ifdef OV7670_PIXEL_WRITER_STATS_EN
    logic [15:0] frameCount;
    logic [7:0]  errorCount;
`endif

    ov7670_pixel_writer #(
        .H_PIXELS(H),
        .V_LINES (V)
    ) dut (
        .writeClk  (clk),
        .rstN      (rstN),
        .vsync     (vsync),
        .href      (href),
        .camData   (camData),
        .pixelOut  (pixelOut),
        .pixelValid(pixelValid),
        .outX      (outX),
        .outY      (outY),
        .lineDone  (lineDone),
        .frameDone (frameDone),
        .lineError (lineError)
`ifdef OV7670_PIXEL_WRITER_STATS_EN
        ,
        .frameCount(frameCount),
        .errorCount(errorCount)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [11:0] pix;
        logic [9:0]  x;
        logic [1:0]  y;
    } pev_t;

    pev_t obs_q[$];
    pev_t exp_q[$];
    int   ld_cnt = 0;
    int   fd_cnt = 0;

    // Observe strobes away from the active edge.
    always @(negedge clk) begin
        if (rstN) begin
            if (pixelValid) begin
                pev_t o;
                o.pix = pixelOut;
                o.x   = outX;
                o.y   = outY;
                obs_q.push_back(o);
                chk("outx_in_range", int'(outX < H), 1);
            end
            if (lineDone)  ld_cnt++;
            if (frameDone) fd_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        vsync   = v;
        href    = h;
        camData = d;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        ld_cnt = 0;
        fd_cnt = 0;
    endtask

    int lens[8];
    bit fixed_pat = 0;

    // Drives one frame of lens[0..nl-1] bytes per line and checks it against
    // the expected pixel list derived directly from the bytes sent.
    task automatic run_frame(input int nl);
        logic [7:0] b[$];
        logic [7:0] d;
        pev_t       e;
        bit         exp_err;
        int         exp_ld;
        int         npix;
        exp_err = 0;
        exp_ld  = 0;
        clear_obs();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("err_clear_at_frame_start", lineError, 0);
        chk("outy_clear_at_frame_start", outY, 0);
        for (int j = 0; j < nl; j++) begin
            b.delete();
            for (int k = 0; k < lens[j]; k++) begin
                if (fixed_pat) d = (k % 2 == 0) ? 8'h0A : 8'hBC;
                else           d = 8'($urandom);
                b.push_back(d);
                step(1'b0, 1'b1, d);
                if (k % 2 == 1) chk("vld_after_low_byte", pixelValid, int'((j < V) && (k / 2 < H)));
                else            chk("vld_gap_after_high_byte", pixelValid, 0);
            end
            if (j < V) begin
                npix = (lens[j] / 2 < H) ? lens[j] / 2 : H;
                for (int p = 0; p < npix; p++) begin
                    e.pix = {b[2*p][3:0], b[2*p+1]};
                    e.x   = 10'(p);
                    e.y   = 2'(j % 4);
                    exp_q.push_back(e);
                end
                exp_ld++;
                if (lens[j] != 2 * H) exp_err = 1;
            end
            step(1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b0, 8'h00);
        end
        chk("frame_line_error", lineError, int'(exp_err));
        chk("frame_linedone_count", ld_cnt, exp_ld);
        chk("frame_framedone_count", fd_cnt, int'(nl >= V));
        chk("frame_outy_end", outY, ((nl < V) ? nl : V) % 4);
        chk("frame_pixel_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk("pixel_data", obs_q[i].pix, exp_q[i].pix);
            chk("pixel_x", obs_q[i].x, exp_q[i].x);
            chk("pixel_y", obs_q[i].y, exp_q[i].y);
        end
    endtask

    typedef struct {
        logic        v;
        logic        h;
        logic [7:0]  d;
        logic        e_vld;
        logic [11:0] e_pix;
        logic [9:0]  e_x;
        logic [1:0]  e_y;
        logic        e_ld;
        logic        e_err;
    } vec_t;

    vec_t tbl[18];

    initial begin
        //            v     h     d       vld   pix      x      y     ld    err
        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 12'h000, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 12'h000, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 12'h000, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 12'h000, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h000, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h0A, 1'b0, 12'h000, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'hBC, 1'b1, 12'hABC, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h05, 1'b0, 12'hABC, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h67, 1'b1, 12'h567, 10'd1, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h567, 10'd1, 2'd1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h567, 10'd1, 2'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'h33, 1'b0, 12'h567, 10'd1, 2'd1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'h567, 10'd1, 2'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h0F, 1'b0, 12'h567, 10'd1, 2'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'h21, 1'b1, 12'hF21, 10'd0, 2'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'hF21, 10'd0, 2'd1, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 12'hF21, 10'd0, 2'd1, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 12'hF21, 10'd0, 2'd0, 1'b0, 1'b0};

        rstN = 1'b0; vsync = 1'b0; href = 1'b0; camData = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", pixelValid, 0);
        chk("reset_pixel", pixelOut, 0);
        chk("reset_outx", outX, 0);
        chk("reset_outy", outY, 0);
        chk("reset_linedone", lineDone, 0);
        chk("reset_framedone", frameDone, 0);
        chk("reset_lineerror", lineError, 0);
        rstN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].h, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), pixelValid, tbl[i].e_vld);
            chk($sformatf("tbl%0d_pixel", i), pixelOut, tbl[i].e_pix);
            chk($sformatf("tbl%0d_outx", i), outX, tbl[i].e_x);
            chk($sformatf("tbl%0d_outy", i), outY, tbl[i].e_y);
            chk($sformatf("tbl%0d_linedone", i), lineDone, tbl[i].e_ld);
            chk($sformatf("tbl%0d_lineerror", i), lineError, tbl[i].e_err);
        end

        // Reset in the middle of a line after a short (erroneous) line.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("pre_reset_lineerror", lineError, 1);
        chk("pre_reset_outy", outY, 1);
        for (int k = 0; k < 51; k++) step(1'b0, 1'b1, 8'hC3);
        #1 rstN = 1'b0;
        #1;
        chk("midreset_valid", pixelValid, 0);
        chk("midreset_pixel", pixelOut, 0);
        chk("midreset_outx", outX, 0);
        chk("midreset_outy", outY, 0);
        chk("midreset_linedone", lineDone, 0);
        chk("midreset_framedone", frameDone, 0);
        chk("midreset_lineerror", lineError, 0);
        #1 rstN = 1'b1;
        clear_obs();
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("href_before_vsync_pixels", obs_q.size(), 0);
        chk("href_before_vsync_linedone", ld_cnt, 0);

        // Five full lines of 0x0A,0xBC; only the first V lines belong to the frame.
        fixed_pat = 1;
        for (int j = 0; j < 5; j++) lens[j] = 2 * H;
        run_frame(5);
        fixed_pat = 0;

        // Odd trailing byte.
        lens[0] = 2 * H + 1;
        run_frame(1);

        // Two extra pixels.
        lens[0] = 2 * H + 4;
        run_frame(1);

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = $urandom_range(1, 5);
            for (int j = 0; j < nl; j++) begin
                case ($urandom_range(0, 5))
                    3:       lens[j] = 2 * H + 1;
                    4:       lens[j] = 2 * H + 4;
                    5:       lens[j] = $urandom_range(1, 2 * H - 1);
                    default: lens[j] = 2 * H;
                endcase
            end
            run_frame(nl);
        end

        // vsync aborts line 2 while a pixel is half-assembled.
        clear_obs();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 2 * H; k++) step(1'b0, 1'b1, (k % 2 == 0) ? 8'h01 : 8'h34);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 201; k++) step(1'b0, 1'b1, 8'h27);
        step(1'b1, 1'b1, 8'h99);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("abort_pixel_count", obs_q.size(), H + 100);
        chk("abort_linedone_count", ld_cnt, 1);
        chk("abort_framedone_count", fd_cnt, 0);
        chk("abort_lineerror", lineError, 0);
        chk("abort_first_pixel", obs_q[0].pix, 12'h134);
        chk("abort_line2_pixel", obs_q[H].pix, 12'h727);
        step(1'b0, 1'b0, 8'h00);
        clear_obs();
        step(1'b0, 1'b1, 8'h0F);
        step(1'b0, 1'b1, 8'h21);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("after_abort_pixel_count", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("after_abort_outx", obs_q[0].x, 0);
            chk("after_abort_outy", obs_q[0].y, 0);
            chk("after_abort_pixel", obs_q[0].pix, 12'hF21);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
